// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM access sequencer.
// Holds the FSM state encoding, the row/column width derivation and the helpers
// that split a word address into a row index and a one-hot column-mux select.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    // Widest address / mux ratio the helpers handle; callers narrow the result.
    localparam int unsigned MAX_ADDR_W  = 32;
    localparam int unsigned MAX_COL_MUX = 64;

    function automatic int unsigned col_width(input int unsigned col_mux);
        return $clog2(col_mux);
    endfunction

    function automatic int unsigned row_width(input int unsigned addr_w, input int unsigned col_mux);
        return addr_w - col_width(col_mux);
    endfunction

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

    // Upper address bits select the wordline.
    function automatic logic [MAX_ADDR_W-1:0] addr_to_row(input logic [MAX_ADDR_W-1:0] addr,
                                                          input int unsigned col_w);
        return addr >> col_w;
    endfunction

    // Low address bits select exactly one column-mux S pin.
    function automatic logic [MAX_COL_MUX-1:0] addr_to_col_onehot(input logic [MAX_ADDR_W-1:0] addr,
                                                                  input int unsigned col_w);
        logic [MAX_ADDR_W-1:0] mask;
        mask = (MAX_ADDR_W'(1) << col_w) - MAX_ADDR_W'(1);
        return MAX_COL_MUX'(1) << (addr & mask);
    endfunction

endpackage

// File: rtl/sram_access_seq_if.sv
// Host-side request/response channel of the SRAM access sequencer.
// master: requester (drives req_*, rsp_ready); slave: sequencer (drives req_ready, rsp_*).
interface sram_access_seq_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_we;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_we, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_we, rsp_rdata
    );
endinterface

// File: rtl/sram_cycle_timer.sv
// Loadable down-counter shared by the precharge and access phases.
// Ports: clk, reset (async, active-high), load/load_val (start a phase),
// count (cycles left including the current one), done_c (current cycle is the last).
module sram_cycle_timer #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             done_c
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign done_c = (count == CNT_W'(1));
endmodule

// File: rtl/sram_access_seq.sv
// Initiator-side sequencer for the compiled SRAM array.
// Ports: clk, reset (async, active-high); host (request/response slave modport);
// array pins pre_en, wl_en, wl_row, col_sel, write_en, bl_wdata, sense_en (all registered)
// and bl_rdata (sense-amp outputs).
module sram_access_seq
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned COL_MUX = 4,
    parameter int unsigned PRE_CYC = 1,
    parameter int unsigned ACC_CYC = 2,
    localparam int unsigned COL_W  = col_width(COL_MUX),
    localparam int unsigned ROW_W  = row_width(ADDR_W, COL_MUX)
) (
    input  logic               clk,
    input  logic               reset,
    sram_access_seq_if.slave   host,
    output logic               pre_en,
    output logic               wl_en,
    output logic [ROW_W-1:0]   wl_row,
    output logic [COL_MUX-1:0] col_sel,
    output logic               write_en,
    output logic [DATA_W-1:0]  bl_wdata,
    output logic               sense_en,
    input  logic [DATA_W-1:0]  bl_rdata
);
    localparam int unsigned MAX_CYC = (PRE_CYC > ACC_CYC) ? PRE_CYC : ACC_CYC;
    localparam int unsigned TMR_W   = ($clog2(MAX_CYC + 1) < 2) ? 2 : $clog2(MAX_CYC + 1);

    if (PRE_CYC < 1 || ACC_CYC < 1 || !is_pow2(COL_MUX)) begin : g_bad_params
        $error("sram_access_seq: PRE_CYC and ACC_CYC must be >= 1 and COL_MUX a power of 2");
    end

    seq_state_e        state;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              tmr_load_c;
    logic [TMR_W-1:0]  tmr_val_c;
    logic [TMR_W-1:0]  tmr_count;
    logic              tmr_done_c;
    logic [ROW_W-1:0]  row_c;
    logic [COL_MUX-1:0] col_c;

    // One timer serves both phases: loaded on request accept and again on PRE->ACC.
    assign tmr_load_c = ((state == ST_IDLE) && host.req_valid) ||
                        ((state == ST_PRE) && tmr_done_c);
    assign tmr_val_c  = (state == ST_IDLE) ? TMR_W'(PRE_CYC) : TMR_W'(ACC_CYC);

    assign row_c = ROW_W'(addr_to_row(MAX_ADDR_W'(addr_q), COL_W));
    assign col_c = COL_MUX'(addr_to_col_onehot(MAX_ADDR_W'(addr_q), COL_W));

    sram_cycle_timer #(.CNT_W(TMR_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load_c),
        .load_val (tmr_val_c),
        .count    (tmr_count),
        .done_c   (tmr_done_c)
    );

    // Sequencer FSM with registered array controls and response channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            host.req_ready <= 1'b1;
            host.rsp_valid <= 1'b0;
            host.rsp_we    <= 1'b0;
            host.rsp_rdata <= '0;
            pre_en         <= 1'b0;
            wl_en          <= 1'b0;
            wl_row         <= '0;
            col_sel        <= '0;
            write_en       <= 1'b0;
            bl_wdata       <= '0;
            sense_en       <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (host.req_valid) begin
                        state          <= ST_PRE;
                        host.req_ready <= 1'b0;
                        we_q           <= host.req_we;
                        addr_q         <= host.req_addr;
                        wdata_q        <= host.req_wdata;
                        pre_en         <= 1'b1;
                        // Direction set while every mux S pin is still low.
                        write_en       <= host.req_we;
                    end
                end
                ST_PRE: begin
                    if (tmr_done_c) begin
                        state    <= ST_ACC;
                        pre_en   <= 1'b0;
                        wl_en    <= 1'b1;
                        wl_row   <= row_c;
                        col_sel  <= col_c;
                        bl_wdata <= we_q ? wdata_q : '0;
                        sense_en <= !we_q && (ACC_CYC == 1);
                    end
                end
                ST_ACC: begin
                    if (tmr_done_c) begin
                        state          <= ST_DONE;
                        wl_en          <= 1'b0;
                        wl_row         <= '0;
                        col_sel        <= '0;
                        write_en       <= 1'b0;
                        bl_wdata       <= '0;
                        sense_en       <= 1'b0;
                        host.rsp_valid <= 1'b1;
                        host.rsp_we    <= we_q;
                        host.rsp_rdata <= we_q ? '0 : bl_rdata;
                    end else begin
                        // Sense only in the final access cycle.
                        sense_en <= !we_q && (tmr_count == TMR_W'(2));
                    end
                end
                ST_DONE: begin
                    if (host.rsp_ready) begin
                        state          <= ST_IDLE;
                        host.req_ready <= 1'b1;
                        host.rsp_valid <= 1'b0;
                        host.rsp_we    <= 1'b0;
                        host.rsp_rdata <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
